// File: rtl/vga_timing_pkg.sv
// VGA raster timing: default 640x480@60 constants and phase enums
// shared by the sync controller and its counters.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef enum logic [1:0] {
    H_ACT,
    H_FP,
    H_SYN,
    H_BP
  } h_phase_t;

  typedef enum logic [1:0] {
    V_ACT,
    V_FP,
    V_SYN,
    V_BP
  } v_phase_t;

  function automatic logic sync_level(
    input logic in_sync,
    input logic pol
  );
    return in_sync ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_sync_controller_counter.sv
// Generic up-counter with synchronous Clear, Load and Count;
// priority is Clear > Load > Count.
module counter #(
  parameter int W = 10
) (
  input  logic         Clock,
  input  logic         Clear,
  input  logic         Count,
  input  logic         Load,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  always_ff @(posedge Clock) begin
    if (Clear)
      Q <= '0;
    else if (Load)
      Q <= D;
    else if (Count)
      Q <= Q + 1'b1;
  end

endmodule

// File: rtl/vga_sync_controller.sv
// VGA sync sequencer: two raster counters plus H/V phase FSMs
// decoded into sync, blanking, coordinates and a frame pulse.
module vga_sync_controller
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             PixelEn,
  output logic             HSync,
  output logic             VSync,
  output logic             VideoOn,
  output logic [CNT_W-1:0] X,
  output logic [CNT_W-1:0] Y,
  output logic             FrameStart
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // last count of each phase; the FSM leaves the phase there
  localparam logic [CNT_W-1:0] H_ACT_END =
    CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_FP_END =
    CNT_W'(H_ACTIVE + H_FRONT - 1);
  localparam logic [CNT_W-1:0] H_SYN_END =
    CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);

  localparam logic [CNT_W-1:0] V_ACT_END =
    CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_FP_END =
    CNT_W'(V_ACTIVE + V_FRONT - 1);
  localparam logic [CNT_W-1:0] V_SYN_END =
    CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             v_step;

  h_phase_t h_state, h_next;
  v_phase_t v_state, v_next;

  assign h_wrap = PixelEn & (h_cnt == H_LAST);
  assign v_step = h_wrap;
  assign v_wrap = h_wrap & (v_cnt == V_LAST);

  counter #(.W(CNT_W)) u_h_cnt (
    .Clock (Clock),
    .Clear (Clear),
    .Count (PixelEn),
    .Load  (h_wrap),
    .D     ('0),
    .Q     (h_cnt)
  );

  counter #(.W(CNT_W)) u_v_cnt (
    .Clock (Clock),
    .Clear (Clear),
    .Count (v_step),
    .Load  (v_wrap),
    .D     ('0),
    .Q     (v_cnt)
  );

  always_ff @(posedge Clock) begin
    if (Clear) begin
      h_state <= H_ACT;
      v_state <= V_ACT;
    end else begin
      h_state <= h_next;
      v_state <= v_next;
    end
  end

  always_comb begin
    h_next = h_state;
    if (PixelEn) begin
      unique case (h_state)
        H_ACT: if (h_cnt == H_ACT_END) h_next = H_FP;
        H_FP:  if (h_cnt == H_FP_END)  h_next = H_SYN;
        H_SYN: if (h_cnt == H_SYN_END) h_next = H_BP;
        H_BP:  if (h_cnt == H_LAST)    h_next = H_ACT;
        default: h_next = H_ACT;
      endcase
    end
  end

  // vertical phase moves only on the line-wrap tick
  always_comb begin
    v_next = v_state;
    if (v_step) begin
      unique case (v_state)
        V_ACT: if (v_cnt == V_ACT_END) v_next = V_FP;
        V_FP:  if (v_cnt == V_FP_END)  v_next = V_SYN;
        V_SYN: if (v_cnt == V_SYN_END) v_next = V_BP;
        V_BP:  if (v_cnt == V_LAST)    v_next = V_ACT;
        default: v_next = V_ACT;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear)
      FrameStart <= 1'b0;
    else
      FrameStart <= v_wrap;
  end

  assign HSync   = sync_level(h_state == H_SYN, SYNC_POL);
  assign VSync   = sync_level(v_state == V_SYN, SYNC_POL);
  assign VideoOn = (h_state == H_ACT) & (v_state == V_ACT);
  assign X       = h_cnt;
  assign Y       = v_cnt;

endmodule
